// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state type.
// UART_RX_PARITY_EN adds the PARITY state to the enum.
package uart_pkg;

    localparam int CLK_FREQ       = 100_000_000;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Reset value is a parameter so idle-high lines come up idle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Double-register the input to settle metastability.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB first, one stop bit.
// Define UART_RX_PARITY_EN for an even-parity bit and parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    state_t               r_state;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_ferr;
    logic                 w_rx_s;
    logic                 w_mid;
    logic                 w_full;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad;
    logic                 r_perr;
`endif

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .i_clk  (clk),
        .i_rst_n(rst),
        .i_d    (rx),
        .o_q    (w_rx_s)
    );

    assign w_mid  = baud_tick && (r_tick == MID);
    assign w_full = baud_tick && (r_tick == FULL);

    // Frame FSM: counts ticks to mid-bit and samples the line there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_tick    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_tick  <= '0;
                        r_bit   <= '0;
                    end
                end
                ST_START: begin
                    if (w_mid) begin
                        r_tick  <= '0;
                        r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else if (baud_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_full) begin
                        r_tick  <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end else if (baud_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_full) begin
                        r_tick    <= '0;
                        r_par_bad <= (^r_shift) ^ w_rx_s;
                        r_state   <= ST_STOP;
                    end else if (baud_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_full) begin
                        r_tick  <= '0;
                        r_data  <= r_shift;
                        r_ferr  <= ~w_rx_s;
                        r_done  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        r_perr  <= r_par_bad;
`endif
                        r_state <= ST_IDLE;
                    end else if (baud_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_data   = r_data;
    assign rx_done   = r_done;
    assign frame_err = r_ferr;
    assign rx_busy   = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized frame-level bench for uart_rx.
// Build with UART_RX_PARITY_EN to cover the parity variant.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } frm_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
    logic       w_perr;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   tcnt    = 0;
    logic [7:0] last_data = 8'h00;
    frm_t exp_q[$];
    frm_t obs_q[$];

    uart_rx dut (
        .clk      (clk),
        .rst      (rst),
        .baud_tick(baud_tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_busy  (rx_busy),
`ifdef UART_RX_PARITY_EN
        .frame_err(frame_err),
        .parity_err(w_perr)
`else
        .frame_err(frame_err)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign w_perr = 1'b0;
`endif

    always #5 clk = ~clk;

    // baud_tick once every 4 clocks
    always @(negedge clk) begin
        tcnt      = (tcnt + 1) % 4;
        baud_tick = (tcnt == 0);
    end

    // record every clock that shows rx_done
    initial forever begin
        @(posedge clk);
        #1;
        if (rx_done)
            obs_q.push_back('{d: rx_data, fe: frame_err, pe: w_perr});
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put_bit(logic b, int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(logic [7:0] d, logic stop, logic pbit);
        frm_t f;
        put_bit(1'b0, BIT_CLKS);
        chk("busy_mid", 32'(rx_busy), 32'd1);
        for (int i = 0; i < 8; i++) put_bit(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        put_bit(pbit, BIT_CLKS);
`endif
        if (stop) begin
            put_bit(1'b1, BIT_CLKS);
        end else begin
            put_bit(1'b0, 44);
            put_bit(1'b1, 20 + BIT_CLKS);
        end
        f.d  = d;
        f.fe = ~stop;
        f.pe = ((^d) != pbit);
        exp_q.push_back(f);
        last_data = d;
    endtask

    task automatic check_frames(string tag);
        frm_t e;
        frm_t o;
        rx = 1'b1;
        repeat (150) @(negedge clk);
        chk({tag, "_cnt"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_data"}, 32'(o.d), 32'(e.d));
            chk({tag, "_ferr"}, 32'(o.fe), 32'(e.fe));
`ifdef UART_RX_PARITY_EN
            chk({tag, "_perr"}, 32'(o.pe), 32'(e.pe));
`endif
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       s;
        logic       p;
        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_done", 32'(rx_done), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_perr", 32'(w_perr), 32'd0);
        rst = 1'b1;
        put_bit(1'b1, 20);

        send(8'hA5, 1'b1, 1'b0);
        check_frames("a5");
        chk("a5_idle", 32'(rx_busy), 32'd0);

        put_bit(1'b0, 12);
        put_bit(1'b1, 150);
        chk("glitch_busy", 32'(rx_busy), 32'd0);
        chk("glitch_data", 32'(rx_data), 32'(last_data));
        chk("glitch_cnt", 32'(obs_q.size()), 32'd0);

        send(8'h3C, 1'b0, 1'b0);
        send(8'h01, 1'b1, 1'b1);
        check_frames("ferr");

        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        check_frames("b2b");

        d = 8'hC3;
        put_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) put_bit(d[i], BIT_CLKS);
        put_bit(d[4], 20);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_busy", 32'(rx_busy), 32'd0);
        chk("abort_data", 32'(rx_data), 32'd0);
        rst = 1'b1;
        put_bit(1'b1, 50);
        send(8'h5A, 1'b1, 1'b0);
        check_frames("abort");

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b0);
        send(8'h07, 1'b1, 1'b1);
        check_frames("par");
`endif

        for (int k = 0; k < 20; k++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 4) != 0);
            p = 1'($urandom_range(0, 1));
            send(d, s, p);
            put_bit(1'b1, $urandom_range(0, 40));
        end
        check_frames("rnd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, LSB first.
REQ-002 Parameter OVERSAMPLE, default 16: baud_tick pulses per bit period.
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 baud_tick  input  1  one-clk strobe at 16x the bit rate, produced by the existing tick generator.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 rx_data  output  DATA_BITS  last received byte, held until the next frame completes.
REQ-008 rx_done  output  1  one-clk pulse when a frame completes.
REQ-009 rx_busy  output  1  high from start-bit detection until return to IDLE.
REQ-010 frame_err  output  1  stop-bit status of the last frame, updated together with rx_done.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; every sample references the synchronized value (rx_s).
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP (plus PARITY, see Configuration); a tick counter of width $clog2(OVERSAMPLE) advances only on clocks with baud_tick=1.
REQ-013 IDLE: on rx_s=0, go to START and clear tick counter and bit counter; rx_busy=1 from the next clk.
REQ-014 START: on the tick where the counter reaches OVERSAMPLE/2-1 (mid-bit), rx_s=0 goes to DATA and clears the counter; rx_s=1 is a glitch and returns to IDLE with no rx_done.
REQ-015 DATA: on each tick where the counter reaches OVERSAMPLE-1, shift rx_s into the MSB of the shift register (LSB-first reception) and clear the counter; after DATA_BITS samples, go to STOP.
REQ-016 STOP: on the tick where the counter reaches OVERSAMPLE-1, load rx_data from the shift register, set frame_err = ~rx_s, and pulse rx_done for exactly one clk on the following clock edge; then go to IDLE.
REQ-017 A frame with stop bit 0 SHALL still update rx_data and pulse rx_done with frame_err=1.
REQ-018 The receiver SHALL NOT accept a new start bit while in STOP; IDLE resamples rx_s on the clk after returning, so back-to-back frames with one stop bit are received.
REQ-019 A baud_tick that coincides with a state transition SHALL be consumed by the state being exited; no tick is double-counted.
REQ-020 rx changes between ticks SHALL have no effect except through the sampled values defined above.

Reset
REQ-021 rst=0 SHALL immediately force IDLE, clear both counters, and set rx_data=0, rx_done=0, rx_busy=0, frame_err=0, and the synchronizer flops=1.
REQ-022 Reset asserted mid-frame SHALL abandon the frame without an rx_done pulse; after release, the next falling edge is treated as a new start bit.

Configuration
REQ-023 Macro UART_RX_PARITY_EN: when defined, a PARITY state follows DATA, samples one even-parity bit at mid-bit, and drives an extra output parity_err (1 bit, reset 0) updated together with rx_done; the frame is still delivered on mismatch.
REQ-024 Without UART_RX_PARITY_EN, no PARITY state and no parity_err port exist; DATA goes directly to STOP.

Structure
REQ-025 Package uart_pkg SHALL hold the state enum typedef, the OVERSAMPLE and DATA_BITS defaults, and the CLK_FREQ=100_000_000 constant shared with the tick generator.
REQ-026 Sub-module sync_2ff (1-bit, reset value parameterized, set to 1 here) SHALL implement REQ-011.

Verification (drive baud_tick every 4 clks to shorten simulation, OVERSAMPLE=16)
REQ-027 Frame 0xA5, stop=1 -> rx_data=8'hA5, one rx_done pulse, frame_err=0, rx_busy low afterwards.
REQ-028 rx low for 3 ticks, then high -> no rx_done, FSM back in IDLE, rx_data unchanged.
REQ-029 Frame 0x3C with stop bit 0 -> rx_data=8'h3C, rx_done pulse, frame_err=1; next good frame 0x01 -> frame_err=0.
REQ-030 Back-to-back frames 0x00 then 0xFF, one stop bit each -> two rx_done pulses with data 0x00 then 0xFF.
REQ-031 rst=0 during bit 4 of a frame, released, then frame 0x5A -> no pulse for the aborted frame; rx_data=8'h5A.
REQ-032 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> rx_done pulse with parity_err=1; the same frame with parity bit 1 -> parity_err=0.
